// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared definitions for the BCD countdown counter:
//            the largest decimal digit value, the FSM state type and a
//            digit legality/clamp helper used on the load path.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {illegal, sanitised_digit}: a digit above 'max' is clamped to
    // 'max' and flagged, any other digit passes through unflagged.
    function automatic logic [4:0] bcd_clamp(input logic [3:0] digit,
                                             input logic [3:0] max);
        if (digit > max) begin
            return {1'b1, max};
        end
        return {1'b0, digit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_counter_if
// Purpose  : Control/status bundle of the BCD countdown counter.
// Ports    : master - drives load/load_val/start/stop/tick/wrap_en,
//                     observes count/running/done/tc/load_err
//            slave  - the counter side of the same signals
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  stop;
    logic                  tick;
    logic                  wrap_en;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  done;
    logic                  tc;
    logic                  load_err;

    modport master (
        output load, load_val, start, stop, tick, wrap_en,
        input  count, running, done, tc, load_err
    );

    modport slave (
        input  load, load_val, start, stop, tick, wrap_en,
        output count, running, done, tc, load_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_dec.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_dec
// Purpose  : One-digit combinational BCD decrement, chained through borrow.
// Ports    : digit      in  4  current digit
//            borrow_in  in  1  decrement request from the lower digit
//            max        in  4  value a digit takes when it underflows
//            digit_next out 4  decremented (or unchanged) digit
//            borrow_out out 1  this digit underflowed, borrow from the next
//            is_zero    out 1  current digit is zero
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  wire logic [3:0] digit,
    input  wire logic       borrow_in,
    input  wire logic [3:0] max,
    output logic      [3:0] digit_next,
    output logic            borrow_out,
    output logic            is_zero
);
    logic w_zero;

    assign w_zero     = (digit == 4'd0);
    assign is_zero    = w_zero;
    assign borrow_out = borrow_in & w_zero;

    always_comb begin
        digit_next = digit;
        if (borrow_in) begin
            digit_next = w_zero ? max : (digit - 4'd1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_counter
// Purpose  : Registered N-digit BCD countdown timer with run control,
//            reload-on-underflow and terminal-count signalling.
// Ports    : clk  in  1  system clock, rising edge
//            rst  in  1  asynchronous active-high reset
//            bus  slave modport of bcd_down_counter_if
//                 (load/load_val/start/stop/tick/wrap_en in,
//                  count/running/done/tc/load_err out)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MSD_MAX = 5
)(
    input  wire logic         clk,
    input  wire logic         rst,
    bcd_down_counter_if.slave bus
);
    localparam int         c_width   = 4 * DIGITS;
    localparam logic [3:0] c_msd_max = 4'(MSD_MAX);

    logic [c_width-1:0] r_count;
    logic [c_width-1:0] r_reload;
    state_t             r_state;
    logic               r_tc;
    logic               r_load_err;

    logic [c_width-1:0] w_load_clean;
    logic [c_width-1:0] w_dec;
    logic [DIGITS-1:0]  w_load_bad;
    logic [DIGITS-1:0]  w_digit_zero;
    logic [DIGITS:0]    w_borrow;
    logic               w_count_zero;

    // A constant borrow into digit 0 makes the chain a plain "minus one".
    assign w_borrow[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        // Only the most-significant digit has a reduced ceiling.
        localparam logic [3:0] c_lim = (gi == DIGITS - 1) ? c_msd_max : BCD_MAX;
        logic [4:0] w_clamp;

        assign w_clamp                  = bcd_clamp(bus.load_val[4*gi +: 4], c_lim);
        assign w_load_clean[4*gi +: 4]  = w_clamp[3:0];
        assign w_load_bad[gi]           = w_clamp[4];

        bcd_digit_dec u_dec (
            .digit      (r_count[4*gi +: 4]),
            .borrow_in  (w_borrow[gi]),
            .max        (c_lim),
            .digit_next (w_dec[4*gi +: 4]),
            .borrow_out (w_borrow[gi+1]),
            .is_zero    (w_digit_zero[gi])
        );
    end

    assign w_count_zero = &w_digit_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_reload   <= '0;
            r_state    <= IDLE;
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
            if (bus.load) begin
                r_count    <= w_load_clean;
                r_reload   <= w_load_clean;
                r_state    <= IDLE;
                r_load_err <= |w_load_bad;
            end else if (bus.stop) begin
                if (r_state == RUN) begin
                    r_state <= IDLE;
                end
            end else if (bus.start) begin
                case (r_state)
                    IDLE: r_state <= (!w_count_zero || bus.wrap_en) ? RUN : DONE;
                    DONE: begin
                        if (bus.wrap_en) begin
                            r_state <= RUN;
                            r_count <= r_reload;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end else if (bus.tick && (r_state == RUN)) begin
                // A borrow out of the MSD means the count is already zero;
                // the chain result is meaningless then and is not used.
                if (!w_borrow[DIGITS]) begin
                    r_count <= w_dec;
                    if (w_dec == '0) begin
                        r_tc <= 1'b1;
                        if (!bus.wrap_en) begin
                            r_state <= DONE;
                        end
                    end
                end else if (bus.wrap_en) begin
                    r_count <= r_reload;
                end else begin
                    r_state <= DONE;
                end
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.running  = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.tc       = r_tc;
    assign bus.load_err = r_load_err;
endmodule
`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_down_counter
// Purpose  : Self-checking bench for bcd_down_counter (DIGITS=2, MSD_MAX=5).
//            Vectors carry stimulus plus expected outputs; the expectation is
//            queued when the stimulus is driven and compared after the edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_down_counter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_down_counter_if #(.DIGITS(2)) bus ();

    bcd_down_counter #(
        .DIGITS  (2),
        .MSD_MAX (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      nm;
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       sp;
        logic       tk;
        logic       we;
        logic [7:0] cnt;
        logic       run;
        logic       dn;
        logic       tc;
        logic       le;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input string nm, input logic ld, input logic [7:0] lv,
                                input logic st, input logic sp, input logic tk, input logic we,
                                input logic [7:0] cnt, input logic run, input logic dn,
                                input logic tc, input logic le);
        vec_t v;
        v.nm = nm; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk; v.we = we;
        v.cnt = cnt; v.run = run; v.dn = dn; v.tc = tc; v.le = le;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        bus.load     = v.ld;
        bus.load_val = v.lv;
        bus.start    = v.st;
        bus.stop     = v.sp;
        bus.tick     = v.tk;
        bus.wrap_en  = v.we;
        sb_q.push_back(v);
    endtask

    task automatic check_out();
        vec_t        e;
        logic [11:0] act;
        logic [11:0] exp;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e   = sb_q.pop_front();
        act = {bus.count, bus.running, bus.done, bus.tc, bus.load_err};
        exp = {e.cnt, e.run, e.dn, e.tc, e.le};
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got count=%h run=%b done=%b tc=%b lerr=%b, expected count=%h run=%b done=%b tc=%b lerr=%b",
                     e.nm, bus.count, bus.running, bus.done, bus.tc, bus.load_err,
                     e.cnt, e.run, e.dn, e.tc, e.le);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.load = 1'b0; bus.load_val = 8'h00; bus.start = 1'b0;
        bus.stop = 1'b0; bus.tick = 1'b0;     bus.wrap_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", {bus.count, bus.running, bus.done, bus.tc, bus.load_err}, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        // name, ld, lv, st, sp, tk, we | cnt, run, dn, tc, le
        // Two-digit countdown to zero, stopping there.
        add("ld10",    1, 8'h10, 0, 0, 0, 0, 8'h10, 0, 0, 0, 0);
        add("start10", 0, 8'h00, 1, 0, 0, 0, 8'h10, 1, 0, 0, 0);
        for (int i = 9; i >= 1; i--)
            add("down",  0, 8'h00, 0, 0, 1, 0, 8'(i), 1, 0, 0, 0);
        add("down00",  0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 1, 0);
        add("hold00a", 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
        add("hold00b", 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
        // Wrap mode reloads after zero and keeps running.
        add("ld03",    1, 8'h03, 0, 0, 0, 1, 8'h03, 0, 0, 0, 0);
        add("start03", 0, 8'h00, 1, 0, 0, 1, 8'h03, 1, 0, 0, 0);
        add("w02",     0, 8'h00, 0, 0, 1, 1, 8'h02, 1, 0, 0, 0);
        add("w01",     0, 8'h00, 0, 0, 1, 1, 8'h01, 1, 0, 0, 0);
        add("w00",     0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 0, 1, 0);
        add("wrel",    0, 8'h00, 0, 0, 1, 1, 8'h03, 1, 0, 0, 0);
        add("w02b",    0, 8'h00, 0, 0, 1, 1, 8'h02, 1, 0, 0, 0);
        // Load sanitising.
        add("ld7A",    1, 8'h7A, 0, 0, 0, 0, 8'h59, 0, 0, 0, 1);
        add("idle59",  0, 8'h00, 0, 0, 0, 0, 8'h59, 0, 0, 0, 0);
        add("ld45",    1, 8'h45, 0, 0, 0, 0, 8'h45, 0, 0, 0, 0);
        add("ldF5",    1, 8'hF5, 0, 0, 0, 0, 8'h55, 0, 0, 0, 1);
        // Stop/start control.
        add("ld42",    1, 8'h42, 0, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        add("stopst",  0, 8'h00, 1, 1, 0, 0, 8'h42, 0, 0, 0, 0);
        add("run42",   0, 8'h00, 1, 0, 0, 0, 8'h42, 1, 0, 0, 0);
        add("stop42",  0, 8'h00, 0, 1, 0, 0, 8'h42, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add("hold42", 0, 8'h00, 0, 0, 1, 0, 8'h42, 0, 0, 0, 0);
        add("rerun42", 0, 8'h00, 1, 0, 0, 0, 8'h42, 1, 0, 0, 0);
        add("dn41",    0, 8'h00, 0, 0, 1, 0, 8'h41, 1, 0, 0, 0);
        // Load wins over a coincident tick.
        add("ld20",    1, 8'h20, 0, 0, 0, 0, 8'h20, 0, 0, 0, 0);
        add("start20", 0, 8'h00, 1, 0, 0, 0, 8'h20, 1, 0, 0, 0);
        add("ldtick",  1, 8'h15, 0, 0, 1, 0, 8'h15, 0, 0, 0, 0);
        add("tkidle",  0, 8'h00, 0, 0, 1, 0, 8'h15, 0, 0, 0, 0);
        // Clearing wrap_en at zero, then restart from DONE.
        add("ld02",    1, 8'h02, 0, 0, 0, 1, 8'h02, 0, 0, 0, 0);
        add("start02", 0, 8'h00, 1, 0, 0, 1, 8'h02, 1, 0, 0, 0);
        add("c01",     0, 8'h00, 0, 0, 1, 1, 8'h01, 1, 0, 0, 0);
        add("c00",     0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 0, 1, 0);
        add("clrwrap", 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0);
        add("dnstay",  0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0);
        add("dnwrap",  0, 8'h00, 1, 0, 0, 1, 8'h02, 1, 0, 0, 0);
        add("r01",     0, 8'h00, 0, 0, 1, 1, 8'h01, 1, 0, 0, 0);
        add("sttick",  0, 8'h00, 1, 0, 1, 1, 8'h01, 1, 0, 0, 0);
        // Zero reload in wrap mode never produces tc.
        add("ld00",    1, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
        add("start00", 0, 8'h00, 1, 0, 0, 1, 8'h00, 1, 0, 0, 0);
        add("z0a",     0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 0, 0, 0);
        add("z0b",     0, 8'h00, 0, 0, 1, 1, 8'h00, 1, 0, 0, 0);
        // Lead-in for the asynchronous reset sequence.
        add("ld34",    1, 8'h34, 0, 0, 0, 0, 8'h34, 0, 0, 0, 0);
        add("start34", 0, 8'h00, 1, 0, 0, 0, 8'h34, 1, 0, 0, 0);
        add("dn33",    0, 8'h00, 0, 0, 1, 0, 8'h33, 1, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset in the middle of a cycle while running at 0x33.
        #2;
        rst = 1'b1;
        #1;
        check_now("async_rst", {bus.count, bus.running, bus.done, bus.tc, bus.load_err}, 12'h000);

        // Tick on the first edge after release is ignored (IDLE).
        @(negedge clk);
        rst = 1'b0;
        v = '{nm:"tk_after_rst", ld:0, lv:8'h00, st:0, sp:0, tk:1, we:0,
              cnt:8'h00, run:0, dn:0, tc:0, le:0};
        drive(v);
        @(posedge clk);
        #1;
        check_out();

        // Start at zero without wrap goes straight to DONE.
        v = '{nm:"start_zero", ld:0, lv:8'h00, st:1, sp:0, tk:0, we:0,
              cnt:8'h00, run:0, dn:1, tc:0, le:0};
        apply(v);

        @(negedge clk);
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
